// File: rtl/i2s_shift_out_multi.sv
// Multi-channel I2S / left-justified / TDM transmit serializer.
// Consumes one FIFO frame per frame start and shifts it out MSB-first on bclk falls.
module i2s_shift_out_multi #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_BITS  = 32,
   parameter int NUM_CH     = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data,
   input  logic                         fifo_ready,
   output logic                         fifo_ack,
   input  logic                         enable,
   input  logic [1:0]                   mode,
   input  logic                         bclk,
   input  logic                         lrclk,
   output logic                         data_out,
   output logic                         underrun,
   input  logic                         underrun_clr
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam int BC_W = $clog2(SLOT_BITS);
   localparam logic [1:0]      MODE_I2S = 2'b00;
   localparam logic [1:0]      MODE_LJ  = 2'b01;
   localparam logic [1:0]      MODE_TDM = 2'b10;
   localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(SLOT_BITS - 1);

   typedef enum logic [1:0] {
      DLY_IDLE,
      DLY_WAIT_RISE,
      DLY_WAIT_FALL
   } dly_state_t;

   logic                         bclk_prev;
   logic                         lrclk_prev;
   logic                         bclk_rise;
   logic                         bclk_fall;
   logic                         lrclk_rise;
   logic                         lrclk_fall;
   dly_state_t                   dly_state;
   dly_state_t                   dly_state_nxt;
   logic [CH_W-1:0]              dly_ch;
   logic [CH_W-1:0]              dly_ch_nxt;
   logic                         dly_load;
   logic [SLOT_BITS-1:0]         shift_reg;
   logic [NUM_CH*DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0]        hold_ch [NUM_CH];
   logic [DATA_WIDTH-1:0]        fifo_ch0;
   logic                         armed;
   logic                         tdm_active;
   logic [CH_W-1:0]              slot_idx;
   logic [BC_W-1:0]              bit_cnt;
   logic                         load;
   logic [CH_W-1:0]              load_ch;
   logic                         frame_start;

   function automatic logic [SLOT_BITS-1:0] align_slot(input logic [DATA_WIDTH-1:0] sample);
      return SLOT_BITS'(sample) << (SLOT_BITS - DATA_WIDTH);
   endfunction

   assign bclk_rise  = bclk & ~bclk_prev;
   assign bclk_fall  = ~bclk & bclk_prev;
   assign lrclk_rise = lrclk & ~lrclk_prev;
   assign lrclk_fall = ~lrclk & lrclk_prev;
   assign fifo_ch0   = fifo_data[DATA_WIDTH-1:0];
   assign data_out   = shift_reg[SLOT_BITS-1];

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         hold_ch[c] = hold[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // One-bclk delayed slot start (I2S and TDM): wait for a rise, load on the following fall
   always_ff @(posedge clk) begin
      if (reset) begin
         dly_state <= DLY_IDLE;
         dly_ch    <= '0;
      end else begin
         dly_state <= dly_state_nxt;
         dly_ch    <= dly_ch_nxt;
      end
   end

   always_comb begin
      dly_state_nxt = dly_state;
      dly_ch_nxt    = dly_ch;
      dly_load      = 1'b0;
      case (dly_state)
         DLY_WAIT_RISE: if (bclk_rise) dly_state_nxt = DLY_WAIT_FALL;
         DLY_WAIT_FALL: begin
            if (bclk_fall) begin
               dly_load      = 1'b1;
               dly_state_nxt = DLY_IDLE;
            end
         end
         default: ;
      endcase
      if (mode == MODE_I2S && lrclk_fall) begin
         dly_state_nxt = DLY_WAIT_RISE;
         dly_ch_nxt    = '0;
      end else if (mode == MODE_I2S && lrclk_rise) begin
         dly_state_nxt = DLY_WAIT_RISE;
         dly_ch_nxt    = CH_W'(1);
      end else if (mode == MODE_TDM && lrclk_rise) begin
         dly_state_nxt = DLY_WAIT_RISE;
         dly_ch_nxt    = '0;
      end
      if (!enable) begin
         dly_state_nxt = DLY_IDLE;
         dly_load      = 1'b0;
      end
   end

   always_comb begin
      load    = 1'b0;
      load_ch = '0;
      if (enable) begin
         case (mode)
            MODE_I2S: begin
               load    = dly_load;
               load_ch = dly_ch;
            end
            MODE_LJ: begin
               if (lrclk_fall) begin
                  load = 1'b1;
               end else if (lrclk_rise) begin
                  load    = 1'b1;
                  load_ch = CH_W'(1);
               end
            end
            MODE_TDM: begin
               if (dly_load) begin
                  load = 1'b1;
               end else if (tdm_active && bclk_fall && bit_cnt == LAST_BIT && slot_idx != LAST_CH) begin
                  load    = 1'b1;
                  load_ch = slot_idx + CH_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign frame_start = load && (load_ch == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         bclk_prev  <= 1'b0;
         lrclk_prev <= 1'b0;
         shift_reg  <= '0;
         hold       <= '0;
         armed      <= 1'b0;
         tdm_active <= 1'b0;
         slot_idx   <= '0;
         bit_cnt    <= '0;
         fifo_ack   <= 1'b0;
      end else begin
         bclk_prev  <= bclk;
         lrclk_prev <= lrclk;
         if (!enable) begin
            shift_reg  <= '0;
            hold       <= '0;
            armed      <= 1'b0;
            tdm_active <= 1'b0;
            slot_idx   <= '0;
            bit_cnt    <= '0;
            fifo_ack   <= 1'b0;
         end else begin
            fifo_ack <= frame_start && fifo_ready;
            if (load) begin
               if (frame_start) begin
                  // An empty FIFO replays the held frame rather than sending silence
                  shift_reg <= align_slot(fifo_ready ? fifo_ch0 : hold_ch[0]);
                  armed     <= 1'b1;
                  if (fifo_ready) hold <= fifo_data;
               end else begin
                  shift_reg <= armed ? align_slot(hold_ch[load_ch]) : '0;
               end
            end else if (bclk_fall) begin
               shift_reg <= shift_reg << 1;
            end

            if (frame_start && mode == MODE_TDM) begin
               tdm_active <= 1'b1;
               slot_idx   <= '0;
               bit_cnt    <= '0;
            end else if (tdm_active && bclk_fall) begin
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  if (slot_idx == LAST_CH) tdm_active <= 1'b0;
                  else slot_idx <= slot_idx + CH_W'(1);
               end else begin
                  bit_cnt <= bit_cnt + BC_W'(1);
               end
            end
         end
      end
   end

   // Setting beats clearing when both happen in the same cycle
   always_ff @(posedge clk) begin
      if (reset) underrun <= 1'b0;
      else if (frame_start && !fifo_ready) underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
   end

endmodule

// File: tb/tb_i2s_shift_out_multi.sv
// Bench for i2s_shift_out_multi: drives bclk/lrclk frames and compares the serial
// stream, acks and underrun flag against a frame-level reference model.
module tb_i2s_shift_out_multi;

   localparam int DW  = 24;
   localparam int SB  = 32;
   localparam int NCH = 4;
   localparam logic [1:0] M_I2S = 2'b00;
   localparam logic [1:0] M_LJ  = 2'b01;
   localparam logic [1:0] M_TDM = 2'b10;
   localparam logic [1:0] M_RSV = 2'b11;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH*DW-1:0] fifo_data;
   logic              fifo_ready;
   logic              fifo_ack;
   logic              enable;
   logic [1:0]        mode;
   logic              bclk;
   logic              lrclk;
   logic              data_out;
   logic              underrun;
   logic              underrun_clr;

   int checks  = 0;
   int passes  = 0;
   int ack_cnt = 0;
   logic [NCH*DW-1:0] last_tx;
   logic              exp_underrun;

   i2s_shift_out_multi #(.DATA_WIDTH(DW), .SLOT_BITS(SB), .NUM_CH(NCH)) dut (
      .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
      .fifo_ack(fifo_ack), .enable(enable), .mode(mode), .bclk(bclk), .lrclk(lrclk),
      .data_out(data_out), .underrun(underrun), .underrun_clr(underrun_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (fifo_ack === 1'b1) ack_cnt <= ack_cnt + 1;

   function automatic int frame_bclks(input logic [1:0] md);
      return (md == M_TDM) ? NCH*SB : 2*SB;
   endfunction

   function automatic logic lr_at(input logic [1:0] md, input int i);
      if (md == M_TDM) return (i == 0);
      return (i >= SB);
   endfunction

   // One bclk period of 4 clks; data_out is sampled one clk after the falling edge
   task automatic bclk_cycle(input logic lr, input logic clr, output logic b);
      @(negedge clk);
      bclk = 1'b0;
      lrclk = lr;
      underrun_clr = clr;
      @(negedge clk);
      b = data_out;
      underrun_clr = 1'b0;
      @(negedge clk);
      bclk = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_span(input logic [1:0] md, input int first, input int last,
                           input logic clr0, output logic [127:0] cap);
      logic b;
      cap = '0;
      for (int i = first; i <= last; i++) begin
         bclk_cycle(lr_at(md, i), clr0 && (i == 0), b);
         cap = {cap[126:0], b};
      end
   endtask

   task automatic prelude(input logic [1:0] md, output logic [127:0] cap);
      logic b;
      cap = '0;
      for (int i = 0; i < 4; i++) begin
         bclk_cycle((md == M_TDM) ? 1'b0 : 1'b1, 1'b0, b);
         cap = {cap[126:0], b};
      end
   endtask

   task automatic set_mode(input logic [1:0] md);
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      mode = md;
      enable = 1'b1;
      last_tx = '0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      exp_underrun = 1'b0;
   endtask

   // Reference: frame = concatenated slots {sample, zero pad}, delayed one bclk except in LJ
   task automatic model_frame(input logic [1:0] md, input logic [NCH*DW-1:0] data,
                              input logic rdy, input logic clr,
                              output logic [127:0] exp, output int eacks);
      logic [NCH*DW-1:0] tx;
      int nslot, nb, d, p;
      exp = '0;
      eacks = 0;
      if (md == M_RSV) return;
      tx = rdy ? data : last_tx;
      last_tx = tx;
      eacks = rdy ? 1 : 0;
      if (!rdy) exp_underrun = 1'b1;
      else if (clr) exp_underrun = 1'b0;
      nslot = (md == M_TDM) ? NCH : 2;
      nb = nslot * SB;
      d = (md == M_LJ) ? 0 : 1;
      for (int s = 0; s < nslot; s++) begin
         for (int k = 0; k < DW; k++) begin
            p = s*SB + k + d;
            if (p < nb) exp[nb-1-p] = tx[s*DW + DW-1-k];
         end
      end
   endtask

   task automatic do_frame(input logic [1:0] md, input logic [NCH*DW-1:0] data,
                           input logic rdy, input logic clr,
                           output logic [127:0] got, output int gacks,
                           output logic [127:0] exp, output int eacks);
      int a0;
      fifo_data = data;
      fifo_ready = rdy;
      a0 = ack_cnt;
      run_span(md, 0, frame_bclks(md) - 1, clr, got);
      gacks = ack_cnt - a0;
      model_frame(md, data, rdy, clr, exp, eacks);
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; mode = M_I2S; bclk = 1'b1; lrclk = 1'b1;
      fifo_data = '0; fifo_ready = 1'b0; underrun_clr = 1'b0;
      last_tx = '0; exp_underrun = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (data_out !== 1'b0) $display("FAIL reset_data_out got=%b exp=0", data_out); else passes++;
      checks++; if (fifo_ack !== 1'b0) $display("FAIL reset_fifo_ack got=%b exp=0", fifo_ack); else passes++;
      checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun got=%b exp=0", underrun); else passes++;
   endtask

   task automatic test_fixed(input logic [1:0] md, input logic [NCH*DW-1:0] data, input int nframes);
      logic [127:0] got, exp;
      int gacks, eacks;
      set_mode(md);
      prelude(md, got);
      checks++; if (got !== '0) $display("FAIL prelude_m%0d got=%h exp=0", md, got); else passes++;
      for (int f = 0; f < nframes; f++) begin
         do_frame(md, data, 1'b1, 1'b0, got, gacks, exp, eacks);
         checks++; if (got !== exp) $display("FAIL bits_m%0d_f%0d got=%h exp=%h", md, f, got, exp); else passes++;
         checks++; if (gacks !== eacks) $display("FAIL acks_m%0d_f%0d got=%0d exp=%0d", md, f, gacks, eacks); else passes++;
      end
      checks++; if (underrun !== exp_underrun) $display("FAIL underrun_m%0d got=%b exp=%b", md, underrun, exp_underrun); else passes++;
   endtask

   task automatic test_underrun();
      logic [127:0] got, exp;
      int gacks, eacks;
      logic [NCH*DW-1:0] d;
      logic [1:0] rdy_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      set_mode(M_LJ);
      prelude(M_LJ, got);
      pulse_clr();
      for (int f = 0; f < 4; f++) begin
         if (f == 3) begin
            pulse_clr();
            checks++; if (underrun !== 1'b0) $display("FAIL underrun_clr got=%b exp=0", underrun); else passes++;
         end
         d = {$urandom, $urandom, $urandom};
         do_frame(M_LJ, d, rdy_seq[f][0], (f == 3), got, gacks, exp, eacks);
         checks++; if (got !== exp) $display("FAIL underrun_bits_f%0d got=%h exp=%h", f, got, exp); else passes++;
         checks++; if (gacks !== eacks) $display("FAIL underrun_acks_f%0d got=%0d exp=%0d", f, gacks, eacks); else passes++;
         checks++; if (underrun !== exp_underrun) $display("FAIL underrun_flag_f%0d got=%b exp=%b", f, underrun, exp_underrun); else passes++;
      end
   endtask

   task automatic test_enable_drop();
      logic [127:0] got, exp, cap1, cap2;
      int gacks, eacks, a0;
      logic [NCH*DW-1:0] d;
      d = {48'h0, 24'h123456, 24'hABCDEF};
      set_mode(M_I2S);
      prelude(M_I2S, got);
      do_frame(M_I2S, d, 1'b1, 1'b0, got, gacks, exp, eacks);
      checks++; if (got !== exp) $display("FAIL endrop_first got=%h exp=%h", got, exp); else passes++;
      fifo_data = d;
      fifo_ready = 1'b1;
      a0 = ack_cnt;
      run_span(M_I2S, 0, 3, 1'b0, cap1);
      checks++; if (data_out !== d[DW-3]) $display("FAIL endrop_pre got=%b exp=%b", data_out, d[DW-3]); else passes++;
      enable = 1'b0;
      @(negedge clk);
      checks++; if (data_out !== 1'b0) $display("FAIL endrop_data_next got=%b exp=0", data_out); else passes++;
      checks++; if (ack_cnt - a0 !== 1) $display("FAIL endrop_start_ack got=%0d exp=1", ack_cnt - a0); else passes++;
      a0 = ack_cnt;
      run_span(M_I2S, 4, 41, 1'b0, cap1);
      enable = 1'b1;
      run_span(M_I2S, 42, 63, 1'b0, cap2);
      last_tx = '0;
      checks++; if ((cap1 | cap2) !== '0) $display("FAIL endrop_quiet got=%h/%h exp=0", cap1, cap2); else passes++;
      checks++; if (ack_cnt - a0 !== 0) $display("FAIL endrop_quiet_ack got=%0d exp=0", ack_cnt - a0); else passes++;
      checks++; if (underrun !== exp_underrun) $display("FAIL endrop_underrun got=%b exp=%b", underrun, exp_underrun); else passes++;
      do_frame(M_I2S, d, 1'b1, 1'b0, got, gacks, exp, eacks);
      checks++; if (got !== exp) $display("FAIL endrop_resume got=%h exp=%h", got, exp); else passes++;
      checks++; if (gacks !== 1) $display("FAIL endrop_resume_ack got=%0d exp=1", gacks); else passes++;
   endtask

   task automatic test_reset_mid();
      logic [127:0] got, exp, cap;
      int gacks, eacks, a0;
      logic [NCH*DW-1:0] d;
      d = {$urandom, $urandom, $urandom};
      do_frame(M_I2S, d, 1'b0, 1'b0, got, gacks, exp, eacks);
      checks++; if (underrun !== 1'b1) $display("FAIL rstmid_underrun_set got=%b exp=1", underrun); else passes++;
      d = {$urandom, $urandom, $urandom};
      d[DW-3] = 1'b1;
      fifo_data = d;
      fifo_ready = 1'b1;
      run_span(M_I2S, 0, 3, 1'b0, cap);
      checks++; if (data_out !== 1'b1) $display("FAIL rstmid_pre got=%b exp=1", data_out); else passes++;
      reset = 1'b1;
      @(negedge clk);
      checks++; if ({data_out, fifo_ack, underrun} !== 3'b000) $display("FAIL rstmid_outputs got=%b exp=000", {data_out, fifo_ack, underrun}); else passes++;
      reset = 1'b0;
      exp_underrun = 1'b0;
      last_tx = '0;
      a0 = ack_cnt;
      run_span(M_I2S, 4, 63, 1'b0, cap);
      checks++; if (cap !== '0) $display("FAIL rstmid_quiet got=%h exp=0", cap); else passes++;
      checks++; if (ack_cnt - a0 !== 0) $display("FAIL rstmid_quiet_ack got=%0d exp=0", ack_cnt - a0); else passes++;
      d = {$urandom, $urandom, $urandom};
      do_frame(M_I2S, d, 1'b1, 1'b0, got, gacks, exp, eacks);
      checks++; if (got !== exp) $display("FAIL rstmid_resume got=%h exp=%h", got, exp); else passes++;
      checks++; if (gacks !== 1) $display("FAIL rstmid_resume_ack got=%0d exp=1", gacks); else passes++;
   endtask

   task automatic test_random();
      logic [127:0] got, exp;
      int gacks, eacks;
      logic [NCH*DW-1:0] d;
      logic rdy;
      for (int m = 0; m < 3; m++) begin
         set_mode(2'(m));
         prelude(2'(m), got);
         pulse_clr();
         for (int f = 0; f < 4; f++) begin
            d = {$urandom, $urandom, $urandom};
            rdy = ($urandom_range(0, 3) != 0);
            do_frame(2'(m), d, rdy, 1'b0, got, gacks, exp, eacks);
            checks++; if (got !== exp) $display("FAIL rand_m%0d_f%0d got=%h exp=%h", m, f, got, exp); else passes++;
            checks++; if (gacks !== eacks) $display("FAIL rand_acks_m%0d_f%0d got=%0d exp=%0d", m, f, gacks, eacks); else passes++;
            checks++; if (underrun !== exp_underrun) $display("FAIL rand_underrun_m%0d_f%0d got=%b exp=%b", m, f, underrun, exp_underrun); else passes++;
         end
      end
   endtask

   task automatic test_reserved();
      logic [127:0] got, exp;
      int gacks, eacks;
      set_mode(M_RSV);
      prelude(M_RSV, got);
      for (int f = 0; f < 2; f++) begin
         do_frame(M_RSV, {$urandom, $urandom, $urandom}, 1'b1, 1'b0, got, gacks, exp, eacks);
         checks++; if (got !== exp) $display("FAIL reserved_bits_f%0d got=%h exp=%h", f, got, exp); else passes++;
         checks++; if (gacks !== eacks) $display("FAIL reserved_acks_f%0d got=%0d exp=%0d", f, gacks, eacks); else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_fixed(M_I2S, {48'h0, 24'h123456, 24'hABCDEF}, 3);
      test_fixed(M_LJ, {48'h0, 24'h123456, 24'hABCDEF}, 3);
      test_fixed(M_TDM, {24'h444444, 24'h333333, 24'h222222, 24'h111111}, 2);
      test_underrun();
      test_enable_drop();
      test_reset_mid();
      test_random();
      test_reserved();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
